// File: rtl/mem_1rw_arb_ctrl_pkg.sv
// Shared types for the 1RW memory arbiter: response FSM states and grant codes.
// Latency: none (types only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_pend = 2'd1,
        e_hold = 2'd2
    } rsp_state_e;

    typedef enum logic [1:0] {
        e_gnt_none = 2'd0,
        e_gnt_rd   = 2'd1,
        e_gnt_wr   = 2'd2
    } gnt_e;

endpackage

// File: rtl/mem_1rw_arb_ctrl_if.sv
// Bundles the read client, write client, response and SRAM pins of the arbiter.
// Latency: none (wires only).
// Backpressure: r_ready_o / w_ready_o / data_ready_i handshakes carried through.
interface mem_1rw_arb_ctrl_if #(
    parameter int width_p = 96,
    parameter int els_p   = 64,
    localparam int addr_width_lp = $clog2(els_p)
);
    logic                     r_v_i;
    logic [addr_width_lp-1:0] r_addr_i;
    logic                     r_ready_o;
    logic                     w_v_i;
    logic [addr_width_lp-1:0] w_addr_i;
    logic [width_p-1:0]       w_data_i;
    logic [width_p-1:0]       w_mask_i;
    logic                     w_ready_o;
    logic                     data_v_o;
    logic [width_p-1:0]       data_o;
    logic                     data_ready_i;
    logic                     mem_v_o;
    logic                     mem_w_o;
    logic [addr_width_lp-1:0] mem_addr_o;
    logic [width_p-1:0]       mem_data_o;
    logic [width_p-1:0]       mem_w_mask_o;
    logic [width_p-1:0]       mem_data_i;

    // Controller side
    modport slave (
        input  r_v_i, r_addr_i, w_v_i, w_addr_i, w_data_i, w_mask_i, data_ready_i, mem_data_i,
        output r_ready_o, w_ready_o, data_v_o, data_o,
        output mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o
    );

    // Clients plus memory wrapper side
    modport master (
        output r_v_i, r_addr_i, w_v_i, w_addr_i, w_data_i, w_mask_i, data_ready_i, mem_data_i,
        input  r_ready_o, w_ready_o, data_v_o, data_o,
        input  mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o
    );
endinterface

// File: rtl/mem_1rw_rsp_buffer.sv
// One-entry read response buffer: passes SRAM data through in PEND, holds it in HOLD.
// Latency: response visible the cycle after the read grant, held until accepted.
// Backpressure: rd_ok_o drops while a response is waiting and the consumer is not ready.
module mem_1rw_rsp_buffer
    import mem_arb_pkg::*;
#(
    parameter int width_p = 96
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               rd_gnt_i,
    input  logic               data_ready_i,
    input  logic [width_p-1:0] mem_data_i,
    output logic               rd_ok_o,
    output logic               data_v_o,
    output logic [width_p-1:0] data_o
);

    rsp_state_e         state_r, state_n;
    logic [width_p-1:0] hold_r;
    logic               hold_en;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= e_idle;
        else         state_r <= state_n;
    end

    // Capture SRAM data when the consumer stalls in PEND, since mem_data_i is only valid one cycle
    always_ff @(posedge clk_i) begin
        if (reset_i)      hold_r <= '0;
        else if (hold_en) hold_r <= mem_data_i;
    end

    // Next state, read admissibility and response mux; outputs forced quiet while in reset
    always_comb begin
        state_n  = state_r;
        hold_en  = 1'b0;
        rd_ok_o  = 1'b0;
        data_v_o = 1'b0;
        data_o   = '0;
        unique case (state_r)
            e_idle: begin
                rd_ok_o = 1'b1;
                if (rd_gnt_i) state_n = e_pend;
            end
            e_pend: begin
                rd_ok_o  = data_ready_i;
                data_v_o = 1'b1;
                data_o   = mem_data_i;
                if (rd_gnt_i)          state_n = e_pend;
                else if (data_ready_i) state_n = e_idle;
                else begin
                    hold_en = 1'b1;
                    state_n = e_hold;
                end
            end
            e_hold: begin
                rd_ok_o  = data_ready_i;
                data_v_o = 1'b1;
                data_o   = hold_r;
                if (rd_gnt_i)          state_n = e_pend;
                else if (data_ready_i) state_n = e_idle;
            end
            default: state_n = e_idle;
        endcase
        if (reset_i) begin
            rd_ok_o  = 1'b0;
            data_v_o = 1'b0;
            data_o   = '0;
        end
    end

endmodule

// File: rtl/mem_1rw_arb_ctrl.sv
// Shares one 1RW bit-masked SRAM between a read and a write client; MEM_ARB_RR_EN selects round-robin.
// Latency: grant and SRAM drive combinational; read response one cycle after accept.
// Backpressure: reads stall while an unaccepted response is held; writes only lose to reads in RR mode.
module mem_1rw_arb_ctrl
    import mem_arb_pkg::*;
#(
    parameter int width_p = 96,
    parameter int els_p   = 64,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    mem_1rw_arb_ctrl_if.slave     bus
);

    gnt_e                     gnt;
    logic                     rd_ok;
    logic                     rd_req;
    logic [addr_width_lp-1:0] mem_addr;

    assign rd_req = bus.r_v_i & rd_ok;

`ifdef MEM_ARB_RR_EN
    // 1 when the write client was granted last, so the read client wins the next conflict
    logic rr_last_r;

    // Round-robin grant on conflicts; a read that is not admissible simply loses
    always_comb begin
        gnt = e_gnt_none;
        if (reset_i)                  gnt = e_gnt_none;
        else if (bus.w_v_i && rd_req) gnt = rr_last_r ? e_gnt_rd : e_gnt_wr;
        else if (bus.w_v_i)           gnt = e_gnt_wr;
        else if (rd_req)              gnt = e_gnt_rd;
    end

    // Track last winner, except when the write won only because the read was blocked
    always_ff @(posedge clk_i) begin
        if (reset_i)                                        rr_last_r <= 1'b0;
        else if (gnt == e_gnt_rd)                           rr_last_r <= 1'b0;
        else if (gnt == e_gnt_wr && !(bus.r_v_i && !rd_ok)) rr_last_r <= 1'b1;
    end
`else
    // Fixed priority: write always wins a conflict
    always_comb begin
        gnt = e_gnt_none;
        if (reset_i)        gnt = e_gnt_none;
        else if (bus.w_v_i) gnt = e_gnt_wr;
        else if (rd_req)    gnt = e_gnt_rd;
    end
`endif

    // SRAM pin drive from the granted client; unused fields held at zero
    always_comb begin
        bus.mem_v_o      = 1'b0;
        bus.mem_w_o      = 1'b0;
        mem_addr         = '0;
        bus.mem_data_o   = '0;
        bus.mem_w_mask_o = '0;
        bus.r_ready_o    = 1'b0;
        bus.w_ready_o    = 1'b0;
        unique case (gnt)
            e_gnt_wr: begin
                bus.mem_v_o      = 1'b1;
                bus.mem_w_o      = 1'b1;
                mem_addr         = bus.w_addr_i;
                bus.mem_data_o   = bus.w_data_i;
                bus.mem_w_mask_o = bus.w_mask_i;
                bus.w_ready_o    = 1'b1;
            end
            e_gnt_rd: begin
                bus.mem_v_o   = 1'b1;
                mem_addr      = bus.r_addr_i;
                bus.r_ready_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr_o = mem_addr;

    mem_1rw_rsp_buffer #(
        .width_p (width_p)
    ) u_rsp (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .rd_gnt_i     (gnt == e_gnt_rd),
        .data_ready_i (bus.data_ready_i),
        .mem_data_i   (bus.mem_data_i),
        .rd_ok_o      (rd_ok),
        .data_v_o     (bus.data_v_o),
        .data_o       (bus.data_o)
    );

endmodule

// File: tb/tb_mem_1rw_arb_ctrl.sv
// Bench for mem_1rw_arb_ctrl: directed vectors, a transaction-level model and a bit-masked SRAM model.
// Latency: model expects responses one cycle after accept.
// Backpressure: consumer readiness driven per vector.
module tb_mem_1rw_arb_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_1rw_arb_ctrl_if #(.width_p(96), .els_p(64)) bus ();

    mem_1rw_arb_ctrl #(.width_p(96), .els_p(64)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    // SRAM model: data valid only the cycle after a read, junk otherwise
    logic [95:0] sram [64];
    logic [95:0] junk;
    always @(posedge clk) begin
        if (bus.mem_v_o && !bus.mem_w_o) bus.mem_data_i <= sram[bus.mem_addr_o];
        else                             bus.mem_data_i <= junk;
        if (bus.mem_v_o && bus.mem_w_o)
            sram[bus.mem_addr_o] <= (sram[bus.mem_addr_o] & ~bus.mem_w_mask_o) |
                                    (bus.mem_data_o & bus.mem_w_mask_o);
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction model: one optional outstanding response plus a reference memory
    logic [95:0] ref_mem [64];
    bit          m_pend;
    logic [95:0] m_data;
    bit          m_rr_wr_last;

    always @(negedge clk) begin
        bit          can_rd, g_rd, g_wr;
        logic [95:0] e_addr;
        can_rd = !m_pend || bus.data_ready_i;
        g_rd = 0;
        g_wr = 0;
        if (!reset) begin
            if (bus.w_v_i && bus.r_v_i && can_rd) begin
`ifdef MEM_ARB_RR_EN
                if (m_rr_wr_last) g_rd = 1; else g_wr = 1;
`else
                g_wr = 1;
`endif
            end else if (bus.w_v_i) g_wr = 1;
            else if (bus.r_v_i && can_rd) g_rd = 1;
        end
        e_addr = g_wr ? 96'(bus.w_addr_i) : g_rd ? 96'(bus.r_addr_i) : 96'd0;
        chk("r_ready", bus.r_ready_o, g_rd);
        chk("w_ready", bus.w_ready_o, g_wr);
        chk("mem_v", bus.mem_v_o, g_rd | g_wr);
        chk("mem_w", bus.mem_w_o, g_wr);
        chk("mem_addr", bus.mem_addr_o, e_addr);
        chk("mem_data", bus.mem_data_o, g_wr ? bus.w_data_i : 96'd0);
        chk("mem_mask", bus.mem_w_mask_o, g_wr ? bus.w_mask_i : 96'd0);
        chk("data_v", bus.data_v_o, !reset && m_pend);
        chk("data_o", bus.data_o, (!reset && m_pend) ? m_data : 96'd0);
        if (reset) begin
            m_pend = 0;
            m_rr_wr_last = 0;
        end else begin
            if (g_rd) begin
                m_pend = 1;
                m_data = ref_mem[bus.r_addr_i];
                m_rr_wr_last = 0;
            end else if (m_pend && bus.data_ready_i) m_pend = 0;
            if (g_wr) begin
                ref_mem[bus.w_addr_i] = (ref_mem[bus.w_addr_i] & ~bus.w_mask_i) | (bus.w_data_i & bus.w_mask_i);
                if (!(bus.r_v_i && !can_rd)) m_rr_wr_last = 1;
            end
        end
    end

    // Drive one cycle of inputs just after the edge, return at the following negedge
    task automatic step(input logic rv, input logic [5:0] ra, input logic wv, input logic [5:0] wa,
                        input logic [95:0] wd, input logic [95:0] wm, input logic dr);
        @(posedge clk);
        #1;
        bus.r_v_i = rv; bus.r_addr_i = ra;
        bus.w_v_i = wv; bus.w_addr_i = wa; bus.w_data_i = wd; bus.w_mask_i = wm;
        bus.data_ready_i = dr;
        @(negedge clk);
    endtask

    task automatic idle(input logic dr);
        step(1'b0, 6'd0, 1'b0, 6'd0, 96'd0, 96'd0, dr);
    endtask

    function automatic logic [95:0] val(input int k);
        logic [3:0] n;
        n = 4'(k);
        return {24{n}};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [95:0] pat_a5, ones, exp_mask;
        bit          exp_w;
        pat_a5   = {12{8'hA5}};
        ones     = '1;
        exp_mask = {ones[95:4], 4'h0};
        junk     = {3{32'hDEADBEEF}};
        for (int i = 0; i < 64; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        m_pend = 0; m_data = '0; m_rr_wr_last = 0;
        reset = 1'b1;
        bus.r_v_i = 0; bus.r_addr_i = '0; bus.w_v_i = 0; bus.w_addr_i = '0;
        bus.w_data_i = '0; bus.w_mask_i = '0; bus.data_ready_i = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst data_v", bus.data_v_o, 96'd0);
        chk("rst mem_v", bus.mem_v_o, 96'd0);
        chk("rst r_ready", bus.r_ready_o, 96'd0);

        // Write then read back with ready consumer
        step(0, 0, 1, 6'd5, pat_a5, ones, 1);
        chk("t1 w_ready", bus.w_ready_o, 96'd1);
        chk("t1 mem_addr", bus.mem_addr_o, 96'd5);
        step(1, 6'd5, 0, 0, 96'd0, 96'd0, 1);
        chk("t1 r_ready", bus.r_ready_o, 96'd1);
        chk("t1 mem_w", bus.mem_w_o, 96'd0);
        idle(1);
        chk("t1 data_v", bus.data_v_o, 96'd1);
        chk("t1 data", bus.data_o, pat_a5);
        idle(1);
        chk("t1 idle data_v", bus.data_v_o, 96'd0);

        // Stalled consumer with writes to the same address
        step(1, 6'd5, 0, 0, 96'd0, 96'd0, 0);
        chk("t2 r_ready", bus.r_ready_o, 96'd1);
        step(0, 0, 1, 6'd5, 96'd0, ones, 0);
        chk("t2 w_ready a", bus.w_ready_o, 96'd1);
        chk("t2 data a", bus.data_o, pat_a5);
        step(0, 0, 1, 6'd5, 96'h123, ones, 0);
        chk("t2 w_ready b", bus.w_ready_o, 96'd1);
        chk("t2 data b", bus.data_o, pat_a5);
        step(1, 6'd6, 0, 0, 96'd0, 96'd0, 0);
        chk("t2 blocked r_ready", bus.r_ready_o, 96'd0);
        chk("t2 data c", bus.data_o, pat_a5);
        idle(1);
        chk("t2 data d", bus.data_o, pat_a5);
        idle(1);
        chk("t2 drained", bus.data_v_o, 96'd0);

        // Conflicts with an always-ready consumer
        step(1, 6'd9, 0, 0, 96'd0, 96'd0, 1);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_w = (i % 2 == 0);
`else
            exp_w = 1;
`endif
            step(1, 6'd7, 1, 6'd8, 96'(i), ones, 1);
            chk("t3 w_ready", bus.w_ready_o, 96'(exp_w));
            chk("t3 r_ready", bus.r_ready_o, 96'(!exp_w));
        end
        idle(1);
        idle(1);

        // Back-to-back reads
        for (int k = 1; k <= 3; k++) step(0, 0, 1, 6'(k), val(k), ones, 1);
        step(1, 6'd1, 0, 0, 96'd0, 96'd0, 1);
        chk("t4 r_ready 1", bus.r_ready_o, 96'd1);
        step(1, 6'd2, 0, 0, 96'd0, 96'd0, 1);
        chk("t4 r_ready 2", bus.r_ready_o, 96'd1);
        chk("t4 data 1", bus.data_o, val(1));
        step(1, 6'd3, 0, 0, 96'd0, 96'd0, 1);
        chk("t4 r_ready 3", bus.r_ready_o, 96'd1);
        chk("t4 data 2", bus.data_o, val(2));
        idle(1);
        chk("t4 data 3", bus.data_o, val(3));
        idle(1);
        chk("t4 drained", bus.data_v_o, 96'd0);

        // Bit mask merge
        step(0, 0, 1, 6'd10, ones, ones, 1);
        step(0, 0, 1, 6'd10, 96'd0, 96'h0F, 1);
        step(1, 6'd10, 0, 0, 96'd0, 96'd0, 1);
        idle(1);
        chk("t5 masked", bus.data_o, exp_mask);
        idle(1);

        // Reset while holding a response
        step(1, 6'd5, 0, 0, 96'd0, 96'd0, 0);
        idle(0);
        idle(0);
        chk("t6 in hold", bus.data_v_o, 96'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("t6 rst data_v", bus.data_v_o, 96'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t6 post data_v", bus.data_v_o, 96'd0);
        chk("t6 post mem_v", bus.mem_v_o, 96'd0);
        chk("t6 post mem_addr", bus.mem_addr_o, 96'd0);
        chk("t6 post mem_mask", bus.mem_w_mask_o, 96'd0);
        step(1, 6'd1, 0, 0, 96'd0, 96'd0, 1);
        chk("t6 r_ready", bus.r_ready_o, 96'd1);
        idle(1);
        chk("t6 data", bus.data_o, val(1));
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_1rw_arb_ctrl.md
# mem_1rw_arb_ctrl

Controller that shares one single-port (1RW) bit-masked SRAM wrapper between a read client and a write client. It arbitrates each cycle and drives the memory's v/w/addr/data/mask pins. Because the SRAM's read data is valid only in the cycle after the read, the block captures it into a one-entry response buffer with a valid/ready handshake. It sits between the front-end table logic (fetch lookups, update writes) and the hardened memory wrapper.

## Interface
- width_p, 96, data width
- els_p, 64, memory depth
- addr_width_lp, $clog2(els_p), address width (derived)

- clk_i  in  1  clock
- reset_i  in  1  reset; synchronous, active-high
- r_v_i  in  1  read request valid
- r_addr_i  in  addr_width_lp  read address
- r_ready_o  out  1  read request accepted when r_v_i & r_ready_o
- w_v_i  in  1  write request valid
- w_addr_i  in  addr_width_lp  write address
- w_data_i  in  width_p  write data
- w_mask_i  in  width_p  per-bit write enable
- w_ready_o  out  1  write accepted when w_v_i & w_ready_o
- data_v_o  out  1  read response valid
- data_o  out  width_p  read response data
- data_ready_i  in  1  consumer accepts response when data_v_o & data_ready_i
- mem_v_o, mem_w_o  out  1 each  memory enable / write select
- mem_addr_o  out  addr_width_lp  memory address
- mem_data_o, mem_w_mask_o  out  width_p each  memory write data / mask
- mem_data_i  in  width_p  memory read data (valid the cycle after a read)

## Operation
- Response FSM states: IDLE (no read outstanding), PEND (read issued last cycle; mem_data_i valid now), HOLD (data held in hold_r awaiting consumer).
- data_v_o = (state != IDLE). data_o = mem_data_i in PEND, hold_r in HOLD.
- Read admissible (rd_ok) in IDLE, or in PEND/HOLD when data_ready_i is high this cycle. r_ready_o = rd_ok & read granted. In PEND/HOLD this allows back-to-back reads at full throughput.
- Writes are always admissible. w_ready_o = write granted.
- Grant: exactly one of read/write per cycle. The write client wins a conflict (fixed priority) unless the configuration below applies. With only one client valid, that client is granted, subject to rd_ok.
- Memory drive: on a grant, mem_v_o=1. mem_w_o=1 for writes. mem_addr_o/mem_data_o/mem_w_mask_o come from the granted client.
- mem_data_o/mem_w_mask_o are 0 when no write is granted. mem_addr_o is 0 when idle.
- Transitions:
  - IDLE→PEND on read grant.
  - PEND: read grant → PEND. Otherwise data_ready_i → IDLE. Otherwise capture mem_data_i into hold_r and go to HOLD.
  - HOLD: read grant → PEND. data_ready_i without a read → IDLE. Otherwise stay.
- A write granted in PEND does not corrupt the response: mem_data_i is sampled/passed in the same cycle.
- No forwarding: a read and a write to the same address in consecutive cycles return the memory's pre-write contents only if the read was granted first.

## Timing
- Read latency: request accept at cycle N, response data_v_o at N+1. The response persists until accepted.
- Reset: state=IDLE, hold_r=0, rr_last_r=0. All outputs 0 during and after reset until a request arrives.
- Reset mid-operation discards any PEND/HOLD response; no stale data_v_o follows.
- Grant and ready logic is combinational from r_v_i, w_v_i, data_ready_i and state. There is no combinational path from mem_data_i to any ready output.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on conflicts. rr_last_r records the last granted client, and the other client wins the next conflict. A read loses a conflict automatically if rd_ok=0, and rr_last_r is unchanged in that case.
- MEM_ARB_RR_EN undefined: fixed write priority. rr_last_r is not instantiated.

## Structure
- Shared package mem_arb_pkg: state enum (e_idle, e_pend, e_hold) and grant enum (e_gnt_none, e_gnt_rd, e_gnt_wr).
- One sub-module, mem_1rw_rsp_buffer: the PEND/HOLD FSM plus hold_r, exporting rd_ok. Arbitration and memory-pin muxing stay in the top.

## Test plan
- Write addr 5 data 0xA5A5…, mask all-ones. Next cycle read addr 5 with data_ready_i=1. Response at +1 cycle equals 0xA5A5…, and state returns to IDLE.
- Read addr 5 with data_ready_i=0 for 3 cycles. data_v_o is held with constant data. Writes to addr 5 in those cycles are accepted (w_ready_o=1) and do not change data_o.
- Both r_v_i and w_v_i held for 4 cycles, consumer always ready:
  - Fixed mode: grants W,W,W,W.
  - MEM_ARB_RR_EN mode: W,R,W,R.
- Back-to-back reads of addr 1,2,3 with data_ready_i=1: r_ready_o=1 every cycle, responses on 3 consecutive cycles in order.
- Bit mask: write 0xFF…F, then write 0x0 with mask 0x0F. Read returns 0xFF…F0.
- Assert reset_i while in HOLD. The next cycle data_v_o=0 and all mem_* outputs are 0. A subsequent read works normally.
